// File: rtl/fetch_pc_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_pkg
// Shared definitions for the fetch-PC stage: default reset vector, fetch and
// bundle field widths, the bundle record handed to decode, and the helper that
// aligns a fetch PC to the 64-bit instruction-pair address.
// Optional feature macro used by this slice: FETCH_SKID_BUF_EN.
// -----------------------------------------------------------------------------
package fetch_pc_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h8000_0000;

    localparam int PC_W    = 32;
    localparam int INST_W  = 64;   // one fetch = one instruction pair
    localparam int PRED_W  = 2;    // one predicted-taken bit per slot

    // Everything decode receives alongside fetch_valid_o.
    typedef struct packed {
        logic [INST_W-1:0] instr;
        logic [PC_W-1:0]   pc;
        logic [PRED_W-1:0] pred;
        logic              fault;
    } fetch_bundle_t;

    localparam int BUNDLE_W = $bits(fetch_bundle_t);

    // The cache is addressed per 8-byte instruction pair.
    function automatic logic [PC_W-1:0] icache_line_addr(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// -----------------------------------------------------------------------------
// fetch_skid
// One-entry skid buffer between the instruction cache response and decode.
// Captures a live bundle when decode is not ready, presents it until decode
// accepts, and is discarded on a redirect. Only built with FETCH_SKID_BUF_EN.
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   flush_i        redirect: drop any held bundle
//   in_valid_i     live bundle valid this cycle
//   in_data_i      live bundle (fetch_bundle_t, packed)
//   out_accept_i   decode ready
//   full_o         buffer holds a bundle
//   out_data_o     held bundle
// -----------------------------------------------------------------------------
module fetch_skid
    import fetch_pc_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    input  logic [BUNDLE_W-1:0] in_data_i,
    input  logic                out_accept_i,
    output logic                full_o,
    output logic [BUNDLE_W-1:0] out_data_o
);

    logic                full_q, full_d;
    logic [BUNDLE_W-1:0] data_q, data_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        full_d = full_q;
        data_d = data_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (full_q) begin
            if (out_accept_i) full_d = 1'b0;
        end else if (in_valid_i && !out_accept_i) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (rst_i) full_q <= 1'b0;
        else       full_q <= full_d;
    end

    // NOTE: payload is qualified by full_q, so it carries no reset.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign full_o     = full_q;
    assign out_data_o = data_q;

endmodule

// File: rtl/fetch_pc.sv
// -----------------------------------------------------------------------------
// fetch_pc
// Fetch-PC stage: holds the current fetch PC, issues one outstanding 64-bit
// instruction-cache read at a time, follows the next-PC predictor, redirects
// on branch requests (discarding any in-flight response) and forwards the
// response bundle to decode.
// Configuration: define FETCH_SKID_BUF_EN to add a one-entry skid buffer so
// decode may stall on a response; otherwise a request is only issued while
// decode is ready.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   branch_request_i/branch_pc_i redirect and its target
//   next_pc_f_i, next_taken_f_i  predictor's next PC / taken bits for pc_f_o
//   pc_f_o, pc_accept_o          current fetch PC, PC accepted this cycle
//   icache_rd_o, icache_pc_o     cache read request and aligned address
//   icache_accept_i              cache took the request
//   icache_valid_i/_error_i/_inst_i  cache response
//   fetch_valid_o, fetch_accept_i    bundle handshake with decode
//   fetch_instr_o/_pc_o/_pred_o/_fault_o  bundle fields
// -----------------------------------------------------------------------------
module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_request_i,
    input  logic [31:0] branch_pc_i,
    input  logic [31:0] next_pc_f_i,
    input  logic [1:0]  next_taken_f_i,
    output logic [31:0] pc_f_o,
    output logic        pc_accept_o,
    output logic        icache_rd_o,
    output logic [31:0] icache_pc_o,
    input  logic        icache_accept_i,
    input  logic        icache_valid_i,
    input  logic        icache_error_i,
    input  logic [63:0] icache_inst_i,
    output logic        fetch_valid_o,
    input  logic        fetch_accept_i,
    output logic [63:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic [1:0]  fetch_pred_o,
    output logic        fetch_fault_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [1:0]  req_pred_q, req_pred_d;
    logic        busy_q, busy_d;
    logic        drop_q, drop_d;

    logic          skid_full;
    logic          resp_valid;
    logic          live_valid;
    fetch_bundle_t live_bundle;
    fetch_bundle_t out_bundle;

    // A response only counts while a request is outstanding; a late response
    // for a request abandoned by reset is ignored.
    assign resp_valid = icache_valid_i & busy_q;
    assign live_valid = resp_valid & ~drop_q & ~branch_request_i;

    always_comb begin
        live_bundle.instr = icache_inst_i;
        live_bundle.pc    = req_pc_q;
        live_bundle.pred  = req_pred_q;
        live_bundle.fault = icache_error_i;
    end

`ifdef FETCH_SKID_BUF_EN
    logic [BUNDLE_W-1:0] skid_data;

    fetch_skid u_skid (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (branch_request_i),
        .in_valid_i   (live_valid),
        .in_data_i    (live_bundle),
        .out_accept_i (fetch_accept_i),
        .full_o       (skid_full),
        .out_data_o   (skid_data)
    );

    assign icache_rd_o = ~busy_q & ~skid_full & ~branch_request_i;

    // A held bundle drains before any live response; none can arrive while
    // it is held because a full skid blocks new requests.
    always_comb begin
        fetch_valid_o = live_valid;
        out_bundle    = live_bundle;
        if (skid_full) begin
            fetch_valid_o = ~branch_request_i;
            out_bundle    = fetch_bundle_t'(skid_data);
        end
    end
`else
    assign skid_full = 1'b0;

    // Without a skid the response must be consumed on arrival, so a request
    // is only launched while decode is ready.
    assign icache_rd_o = ~busy_q & ~skid_full & ~branch_request_i & fetch_accept_i;

    always_comb begin
        fetch_valid_o = live_valid;
        out_bundle    = live_bundle;
    end
`endif

    assign pc_accept_o   = icache_rd_o & icache_accept_i;
    assign pc_f_o        = pc_q;
    assign icache_pc_o   = icache_line_addr(pc_q);
    assign fetch_instr_o = out_bundle.instr;
    assign fetch_pc_o    = out_bundle.pc;
    assign fetch_pred_o  = out_bundle.pred;
    assign fetch_fault_o = out_bundle.fault;

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        req_pred_d = req_pred_q;
        busy_d     = busy_q;
        drop_d     = drop_q;

        if (resp_valid) begin
            busy_d = 1'b0;
            drop_d = 1'b0;
        end

        // Redirect wins over a request (icache_rd_o is already low). Only a
        // response still in flight needs to be marked for discard.
        if (branch_request_i) begin
            pc_d = branch_pc_i;
            if (busy_q && !resp_valid) drop_d = 1'b1;
        end else if (pc_accept_o) begin
            pc_d       = next_pc_f_i;
            busy_d     = 1'b1;
            req_pc_d   = pc_q;
            req_pred_d = next_taken_f_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_VECTOR;
            req_pc_q   <= '0;
            req_pred_q <= '0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            req_pred_q <= req_pred_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc
// Self-checking bench for fetch_pc: a table of fetch transactions run in a
// loop with a scoreboard of expected bundles, plus hand-written sequences for
// redirects, reset while busy, and (with FETCH_SKID_BUF_EN) decode stall.
// -----------------------------------------------------------------------------
module tb_fetch_pc;

    localparam logic [31:0] RV = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        branch_request_i;
    logic [31:0] branch_pc_i;
    logic [31:0] next_pc_f_i;
    logic [1:0]  next_taken_f_i;
    logic [31:0] pc_f_o;
    logic        pc_accept_o;
    logic        icache_rd_o;
    logic [31:0] icache_pc_o;
    logic        icache_accept_i;
    logic        icache_valid_i;
    logic        icache_error_i;
    logic [63:0] icache_inst_i;
    logic        fetch_valid_o;
    logic        fetch_accept_i;
    logic [63:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic [1:0]  fetch_pred_o;
    logic        fetch_fault_o;

    fetch_pc #(.RESET_VECTOR(RV)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .branch_request_i (branch_request_i),
        .branch_pc_i      (branch_pc_i),
        .next_pc_f_i      (next_pc_f_i),
        .next_taken_f_i   (next_taken_f_i),
        .pc_f_o           (pc_f_o),
        .pc_accept_o      (pc_accept_o),
        .icache_rd_o      (icache_rd_o),
        .icache_pc_o      (icache_pc_o),
        .icache_accept_i  (icache_accept_i),
        .icache_valid_i   (icache_valid_i),
        .icache_error_i   (icache_error_i),
        .icache_inst_i    (icache_inst_i),
        .fetch_valid_o    (fetch_valid_o),
        .fetch_accept_i   (fetch_accept_i),
        .fetch_instr_o    (fetch_instr_o),
        .fetch_pc_o       (fetch_pc_o),
        .fetch_pred_o     (fetch_pred_o),
        .fetch_fault_o    (fetch_fault_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] next_pc;
        logic [1:0]  pred;
        int          acc_delay;
        int          lat;
        logic [63:0] instr;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [63:0] instr;
        logic [31:0] pc;
        logic [1:0]  pred;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_pc;
    int          checks = 0;
    int          passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 2 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic expect_bundle(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_valid"}, fetch_valid_o, 1'b1);
            check({tag, "_instr"}, fetch_instr_o, e.instr);
            check({tag, "_pc"},    fetch_pc_o,    e.pc);
            check({tag, "_pred"},  fetch_pred_o,  e.pred);
            check({tag, "_fault"}, fetch_fault_o, e.fault);
        end
    endtask

    // Issue the request at model_pc, then return its response after lat cycles.
    task automatic do_txn(input vec_t v, input string tag);
        next_pc_f_i     = v.next_pc;
        next_taken_f_i  = v.pred;
        icache_accept_i = 1'b0;
        for (int d = 0; d < v.acc_delay; d++) begin
            #1;
            check({tag, "_wait_rd"},  icache_rd_o, 1'b1);
            check({tag, "_wait_pc"},  icache_pc_o, {model_pc[31:3], 3'b000});
            check({tag, "_wait_acc"}, pc_accept_o, 1'b0);
            tick();
        end
        icache_accept_i = 1'b1;
        #1;
        check({tag, "_req_pc"}, icache_pc_o, {model_pc[31:3], 3'b000});
        check({tag, "_accept"}, pc_accept_o, 1'b1);
        sb.push_back('{instr: v.instr, pc: model_pc, pred: v.pred, fault: v.err});
        tick();
        icache_accept_i = 1'b0;
        model_pc = v.next_pc;
        #1;
        check({tag, "_pc_f"}, pc_f_o, model_pc);
        for (int l = 1; l < v.lat; l++) begin
            check({tag, "_busy_rd"}, icache_rd_o, 1'b0);
            check({tag, "_busy_fv"}, fetch_valid_o, 1'b0);
            tick();
            #1;
        end
        icache_valid_i = 1'b1;
        icache_inst_i  = v.instr;
        icache_error_i = v.err;
        #1;
        expect_bundle(tag);
        tick();
        icache_valid_i = 1'b0;
        icache_error_i = 1'b0;
        #1;
        check({tag, "_rd_again"}, icache_rd_o, 1'b1);
    endtask

    vec_t vecs[6];
    vec_t v;

    initial begin
        vecs[0] = '{32'h8000_0010, 2'b00, 0, 1, 64'h0000_0013_0000_0013, 1'b0};
        vecs[1] = '{32'h8000_0018, 2'b01, 3, 2, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
        vecs[2] = '{32'hFFFF_FFFC, 2'b10, 0, 4, 64'h1111_2222_3333_4444, 1'b1};
        vecs[3] = '{32'h0000_0004, 2'b11, 1, 1, 64'h5555_6666_7777_8888, 1'b0};
        vecs[4] = '{32'h0000_000C, 2'b00, 2, 3, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[5] = '{32'h8000_0000, 2'b01, 0, 2, 64'hFEDC_BA98_7654_3210, 1'b1};

        rst_i            = 1'b1;
        branch_request_i = 1'b0;
        branch_pc_i      = '0;
        next_pc_f_i      = '0;
        next_taken_f_i   = '0;
        icache_accept_i  = 1'b0;
        icache_valid_i   = 1'b0;
        icache_error_i   = 1'b0;
        icache_inst_i    = '0;
        fetch_accept_i   = 1'b1;
        #1;
        check("rst_pc_f",      pc_f_o,        RV);
        check("rst_pc_accept", pc_accept_o,   1'b0);
        check("rst_fvalid",    fetch_valid_o, 1'b0);
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        check("post_rst_rd", icache_rd_o, 1'b1);
        check("post_rst_pc", icache_pc_o, RV);
        model_pc = RV;

        // Table-driven transactions.
        for (int i = 0; i < 6; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Redirect while a response is in flight: response discarded.
        next_pc_f_i = 32'h8000_0008;
        icache_accept_i = 1'b1;
        #1;
        check("br_accept", pc_accept_o, 1'b1);
        tick();
        icache_accept_i  = 1'b0;
        branch_request_i = 1'b1;
        branch_pc_i      = 32'h0000_0100;
        #1;
        check("br_rd_blocked", icache_rd_o,   1'b0);
        check("br_fvalid",     fetch_valid_o, 1'b0);
        model_pc = 32'h0000_0100;
        tick();
        branch_request_i = 1'b0;
        #1;
        check("br_pc_f",   pc_f_o,      model_pc);
        check("br_busy",   icache_rd_o, 1'b0);
        tick();
        icache_valid_i = 1'b1;
        icache_inst_i  = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        check("br_dropped", fetch_valid_o, 1'b0);
        tick();
        icache_valid_i = 1'b0;
        #1;
        check("br_new_rd", icache_rd_o, 1'b1);
        check("br_new_pc", icache_pc_o, 32'h0000_0100);

        // Redirect coincident with the response: discarded, nothing left to drop.
        next_pc_f_i = 32'h0000_0108;
        icache_accept_i = 1'b1;
        tick();
        icache_accept_i  = 1'b0;
        icache_valid_i   = 1'b1;
        branch_request_i = 1'b1;
        branch_pc_i      = 32'h0000_0200;
        #1;
        check("brv_fvalid", fetch_valid_o, 1'b0);
        tick();
        icache_valid_i   = 1'b0;
        branch_request_i = 1'b0;
        model_pc = 32'h0000_0200;
        #1;
        check("brv_rd", icache_rd_o, 1'b1);
        check("brv_pc", icache_pc_o, 32'h0000_0200);
        v = '{32'h0000_0208, 2'b10, 0, 1, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0};
        do_txn(v, "brv_after");

        // Reset while busy, with a late response after release.
        next_pc_f_i = 32'h0000_0300;
        icache_accept_i = 1'b1;
        tick();
        icache_accept_i = 1'b0;
        rst_i           = 1'b1;
        icache_valid_i  = 1'b1;
        icache_inst_i   = 64'h7777_7777_7777_7777;
        #1;
        check("rb_pc_f",   pc_f_o,        RV);
        check("rb_acc",    pc_accept_o,   1'b0);
        check("rb_fvalid", fetch_valid_o, 1'b0);
        sb.delete();
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        check("rb_late_ignored", fetch_valid_o, 1'b0);
        check("rb_rd",           icache_rd_o,   1'b1);
        check("rb_pc",           icache_pc_o,   RV);
        model_pc = RV;
        tick();
        icache_valid_i = 1'b0;
        v = '{32'h8000_0040, 2'b11, 1, 2, 64'h1357_9BDF_2468_ACE0, 1'b0};
        do_txn(v, "rb_after");

`ifdef FETCH_SKID_BUF_EN
        // Decode stalls on a response: held in the skid, no new request.
        next_pc_f_i    = 32'h8000_0048;
        next_taken_f_i = 2'b01;
        icache_accept_i = 1'b1;
        #1;
        sb.push_back('{instr: 64'h0000_0013_0000_0013, pc: model_pc, pred: 2'b01, fault: 1'b0});
        tick();
        icache_accept_i = 1'b0;
        fetch_accept_i  = 1'b0;
        icache_valid_i  = 1'b1;
        icache_inst_i   = 64'h0000_0013_0000_0013;
        #1;
        check("skid_live_valid", fetch_valid_o, 1'b1);
        tick();
        icache_valid_i = 1'b0;
        icache_inst_i  = '0;
        #1;
        check("skid_hold_valid", fetch_valid_o, 1'b1);
        check("skid_hold_instr", fetch_instr_o, 64'h0000_0013_0000_0013);
        check("skid_no_rd",      icache_rd_o,   1'b0);
        tick();
        fetch_accept_i = 1'b1;
        #1;
        expect_bundle("skid_drain");
        tick();
        #1;
        check("skid_empty", fetch_valid_o, 1'b0);
        check("skid_rd",    icache_rd_o,   1'b1);
`endif

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule
